mem_access_unit: RTL and testbench

- Parametrised next-generation MEM pipeline stage for the RV32I core. Sits between the EX/MEM latch and the MEM/WB latch.
- Decodes load/store operations by RISC-V funct3 and services loads from the DCache on a hit with zero wait.
- Otherwise issues an explicit req/ack transaction to the memory controller. Holds the loaded result in a register until the pipeline advances, so no stallreq feedback register is needed.
- Adds configurable misalignment handling and DCache update on stores and word-load fills.

---
 rtl/mem_access_unit_pkg.sv | 33 +++
 rtl/mem_access_unit_if.sv | 40 ++++
 rtl/mem_access_unit_load_extend.sv | 27 ++
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the RV32I MEM stage: funct3 encodings, FSM states,
// stall-request levels and the access-size decode helper.
package mem_access_unit_pkg;

    // Load funct3 encodings. Stores reuse the low three (SB=000, SH=001, SW=010).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Byte count of an access; 0 marks a funct3 that is not a memory op.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: size_of = 3'd1;
            F3_LH, F3_LHU: size_of = 3'd2;
            F3_LW:         size_of = 3'd4;
            default:       size_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the MEM stage: memory controller req/ack channel and
// DCache lookup/update port.
//
// Handshake: mc_req_o rises the cycle after a request is accepted and stays
// high, with every mc_* output stable, up to and including the cycle in which
// the controller pulses mc_ack_i for one cycle (mc_rdata_i valid with it).
// mc_ack_i is ignored while mc_req_o is low; dropping mc_req_o before the ack
// (reset) aborts the transaction.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              mc_req_o;
    logic              mc_we_o;
    logic [ADDR_W-1:0] mc_addr_o;
    logic [XLEN-1:0]   mc_wdata_o;
    logic [2:0]        mc_len_o;
    logic              mc_ack_i;
    logic [XLEN-1:0]   mc_rdata_i;
    logic [ADDR_W-1:0] dc_addr_o;
    logic              dc_hit_i;
    logic [XLEN-1:0]   dc_rdata_i;
    logic              dc_wr_o;
    logic [3:0]        dc_be_o;
    logic [XLEN-1:0]   dc_wdata_o;

    modport master (
        output mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o, mc_len_o,
        input  mc_ack_i, mc_rdata_i,
        output dc_addr_o, dc_wr_o, dc_be_o, dc_wdata_o,
        input  dc_hit_i, dc_rdata_i
    );

    modport slave (
        input  mc_req_o, mc_we_o, mc_addr_o, mc_wdata_o, mc_len_o,
        output mc_ack_i, mc_rdata_i,
        input  dc_addr_o, dc_wr_o, dc_be_o, dc_wdata_o,
        output dc_hit_i, dc_rdata_i
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Lane select plus sign/zero extension of load data. Shared by the DCache
// hit path (real byte offset) and the controller ack path (offset 0, data
// already low-aligned).
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by load type.
    always_comb begin
        shifted = data >> {offset, 3'b000};
        result  = ZERO_WORD;
        case (funct3)
            F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = data;
            F3_LBU:  result = {24'h0, shifted[7:0]};
            F3_LHU:  result = {16'h0, shifted[15:0]};
            default: result = ZERO_WORD;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: zero-wait loads on DCache hit, otherwise a req/ack
// transaction to the memory controller whose result is held in HOLD until
// the pipeline advances. Stores and aligned word fills update the DCache.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int REG_AW           = 5,
    parameter int PIPE_DEPTH       = 6,
    parameter int MEM_STAGE        = 3,
    parameter int USE_DCACHE       = 1,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_op_i,
    input  logic                  mem_en_i,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic [REG_AW-1:0]     rd_addr_i,
    input  logic                  rd_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    output logic [XLEN-1:0]       rd_data_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic                  rd_we_o,
    mem_access_unit_if.master     bus,
    input  logic [PIPE_DEPTH-1:0] stall_i,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output state_t                dbg_state
);
    localparam bit DC_EN = (USE_DCACHE != 0);

    state_t            state;
    logic              mc_req;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN-1:0]   cap_data;
    logic [2:0]        req_len;
    logic [2:0]        req_funct3;
    logic              req_we;
    logic              req_mis;
    logic [REG_AW-1:0] req_rd_addr;

    // Only the MEM stage's own stall bit matters here.
    logic unused_stall;
    assign unused_stall = ^stall_i;

    // Decode of the incoming instruction (only acted on in IDLE).
    logic [2:0] funct3;
    logic [2:0] size;
    logic       is_store, is_mem, misaligned, trap, hit, start;
    assign funct3     = mem_op_i[2:0];
    assign is_store   = mem_op_i[3];
    assign size       = size_of(funct3);
    assign is_mem     = mem_en_i && (size != 3'd0);
    assign misaligned = ((size == 3'd2) && mem_addr_i[0]) ||
                        ((size == 3'd4) && (mem_addr_i[1:0] != 2'b00));
    assign trap       = is_mem && misaligned && (ALLOW_MISALIGNED == 0);
    assign hit        = is_mem && !is_store && !misaligned && DC_EN && bus.dc_hit_i;
    assign start      = is_mem && !trap && !hit;

    // One extender: ack data while in REQ, DCache word otherwise.
    logic        in_req;
    logic [31:0] ext_result;
    assign in_req = (state == S_REQ);

    mem_access_unit_load_extend u_load_extend (
        .data   (in_req ? bus.mc_rdata_i : bus.dc_rdata_i),
        .offset (in_req ? 2'b00 : mem_addr_i[1:0]),
        .funct3 (in_req ? req_funct3 : funct3),
        .result (ext_result)
    );

    // Control FSM with request registers, registered mc_req and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mc_req      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_len     <= 3'd0;
            req_funct3  <= 3'd0;
            req_we      <= 1'b0;
            req_mis     <= 1'b0;
            req_rd_addr <= '0;
            cap_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_REQ;
                        mc_req      <= 1'b1;
                        req_addr    <= mem_addr_i;
                        req_wdata   <= rd_data_i;
                        req_len     <= size;
                        req_funct3  <= funct3;
                        req_we      <= is_store;
                        req_mis     <= misaligned;
                        req_rd_addr <= rd_addr_i;
                    end
                end
                S_REQ: begin
                    if (bus.mc_ack_i) begin
                        state    <= S_HOLD;
                        mc_req   <= 1'b0;
                        cap_data <= req_we ? '0 : ext_result;
                    end
                end
                S_HOLD: begin
                    if (!stall_i[MEM_STAGE]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pipeline-side outputs; everything reads 0 while reset is held.
    always_comb begin
        rd_data_o  = '0;
        rd_addr_o  = '0;
        rd_we_o    = 1'b0;
        stallreq_o = STALL_DISABLE;
        misalign_o = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        rd_data_o = rd_data_i;
                        rd_addr_o = rd_addr_i;
                        rd_we_o   = rd_we_i;
                    end else if (trap) begin
                        rd_addr_o  = rd_addr_i;
                        misalign_o = 1'b1;
                    end else if (hit) begin
                        rd_data_o = ext_result;
                        rd_addr_o = rd_addr_i;
                        rd_we_o   = (rd_addr_i != '0);
                    end else begin
                        stallreq_o = STALL_ENABLE;
                    end
                end
                S_REQ: stallreq_o = STALL_ENABLE;
                S_HOLD: begin
                    rd_data_o = cap_data;
                    rd_addr_o = req_rd_addr;
                    rd_we_o   = !req_we && (req_rd_addr != '0);
                end
                default: ;
            endcase
        end
    end

    // Memory controller side comes straight from registers.
    assign bus.mc_req_o   = mc_req;
    assign bus.mc_we_o    = mc_req && req_we;
    assign bus.mc_addr_o  = mc_req ? req_addr : '0;
    assign bus.mc_wdata_o = (mc_req && req_we) ? req_wdata : '0;
    assign bus.mc_len_o   = mc_req ? req_len : 3'd0;

    // DCache update on store ack, or fill on aligned LW ack; misaligned
    // accesses never touch the cache.
    logic       ack_in_req, store_upd, fill_upd;
    logic [3:0] be_base;
    assign ack_in_req = in_req && bus.mc_ack_i;
    assign store_upd  = DC_EN && ack_in_req && req_we && !req_mis;
    assign fill_upd   = DC_EN && ack_in_req && !req_we && (req_funct3 == F3_LW) && !req_mis;
    assign be_base    = (req_len == 3'd1) ? 4'b0001 :
                        (req_len == 3'd2) ? 4'b0011 : 4'b1111;

    assign bus.dc_addr_o  = (!rst || !DC_EN) ? '0 : (in_req ? req_addr : mem_addr_i);
    assign bus.dc_wr_o    = store_upd || fill_upd;
    assign bus.dc_be_o    = store_upd ? (be_base << req_addr[1:0]) :
                            fill_upd  ? 4'hF : 4'h0;
    assign bus.dc_wdata_o = store_upd ? (req_wdata << {req_addr[1:0], 3'b000}) :
                            fill_upd  ? bus.mc_rdata_i : '0;

    assign dbg_state = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one DUT with misaligned forwarding,
// one with misaligned trapping, sharing pipeline and memory-side stimulus.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  mem_op;
    logic        mem_en;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic [31:0] mem_addr;
    logic [5:0]  stall;

    logic [31:0] rd_data_o, rd_data_o2;
    logic [4:0]  rd_addr_o, rd_addr_o2;
    logic        rd_we_o, rd_we_o2;
    logic        stallreq, stallreq2, misalign, misalign2;
    state_t      st, st2;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();
    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) bus2 ();

    assign bus2.mc_ack_i   = bus.mc_ack_i;
    assign bus2.mc_rdata_i = bus.mc_rdata_i;
    assign bus2.dc_hit_i   = bus.dc_hit_i;
    assign bus2.dc_rdata_i = bus.dc_rdata_i;

    mem_access_unit #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst), .mem_op_i(mem_op), .mem_en_i(mem_en),
        .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .mem_addr_i(mem_addr), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o), .bus(bus), .stall_i(stall), .stallreq_o(stallreq),
        .misalign_o(misalign), .dbg_state(st)
    );

    mem_access_unit #(.ALLOW_MISALIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .mem_op_i(mem_op), .mem_en_i(mem_en),
        .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .mem_addr_i(mem_addr), .rd_data_o(rd_data_o2), .rd_addr_o(rd_addr_o2),
        .rd_we_o(rd_we_o2), .bus(bus2), .stall_i(stall), .stallreq_o(stallreq2),
        .misalign_o(misalign2), .dbg_state(st2)
    );

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_en    = 1'b0;
        mem_op    = 4'h0;
        rd_data_i = 32'h5A5A_5A5A;
        rd_addr_i = 5'd31;
        rd_we_i   = 1'b1;
        mem_addr  = 32'hFFFF_FFF0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd);
        mem_en    = 1'b1;
        mem_op    = op;
        mem_addr  = addr;
        rd_data_i = data;
        rd_addr_i = rd;
        rd_we_i   = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        #2;
        total++; if (rd_data_o !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data_o, 32'h0); end
        total++; if (rd_addr_o !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr_o); end
        total++; if (rd_we_o !== 1'b0) begin bad++; $display("FAIL reset_rd_we got=%b exp=0", rd_we_o); end
        total++; if (bus.mc_req_o !== 1'b0) begin bad++; $display("FAIL reset_mc_req got=%b exp=0", bus.mc_req_o); end
        total++; if (bus.dc_addr_o !== 32'h0) begin bad++; $display("FAIL reset_dc_addr got=%h exp=0", bus.dc_addr_o); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stallreq got=%b exp=0", stallreq); end
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st, S_IDLE); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_passthrough;
        tick();
        mem_en = 1'b0; rd_data_i = 32'h0000_1234; rd_addr_i = 5'd5; rd_we_i = 1'b1;
        #1;
        total++; if (rd_data_o !== 32'h0000_1234) begin bad++; $display("FAIL pass_data got=%h exp=%h", rd_data_o, 32'h1234); end
        total++; if (rd_addr_o !== 5'd5) begin bad++; $display("FAIL pass_addr got=%0d exp=5", rd_addr_o); end
        total++; if (rd_we_o !== 1'b1) begin bad++; $display("FAIL pass_we got=%b exp=1", rd_we_o); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL pass_stallreq got=%b exp=0", stallreq); end
        idle_inputs();
    endtask

    task automatic test_load_miss(input logic [3:0] op, input logic [31:0] exp);
        tick();
        drive_op(op, 32'h0000_1001, 32'h0, 5'd5);
        bus.dc_hit_i = 1'b0;
        #1;
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL miss_stallreq op=%h got=%b exp=1", op, stallreq); end
        total++; if (bus.mc_req_o !== 1'b0) begin bad++; $display("FAIL miss_req_early op=%h got=%b exp=0", op, bus.mc_req_o); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.mc_req_o !== 1'b1) begin bad++; $display("FAIL miss_req op=%h got=%b exp=1", op, bus.mc_req_o); end
        total++; if (bus.mc_addr_o !== 32'h0000_1001) begin bad++; $display("FAIL miss_addr op=%h got=%h exp=%h", op, bus.mc_addr_o, 32'h1001); end
        total++; if (bus.mc_len_o !== 3'd1) begin bad++; $display("FAIL miss_len op=%h got=%0d exp=1", op, bus.mc_len_o); end
        total++; if (bus.mc_we_o !== 1'b0) begin bad++; $display("FAIL miss_we op=%h got=%b exp=0", op, bus.mc_we_o); end
        total++; if (rd_we_o !== 1'b0 || stallreq !== 1'b1) begin bad++; $display("FAIL miss_req_outs op=%h got we=%b stall=%b exp we=0 stall=1", op, rd_we_o, stallreq); end
        tick();
        tick();
        total++; if (bus.mc_req_o !== 1'b1) begin bad++; $display("FAIL miss_req_held op=%h got=%b exp=1", op, bus.mc_req_o); end
        tick();
        bus.mc_ack_i = 1'b1; bus.mc_rdata_i = 32'h0000_00F0;
        tick();
        bus.mc_ack_i = 1'b0; bus.mc_rdata_i = 32'h0;
        #1;
        total++; if (st !== S_HOLD) begin bad++; $display("FAIL miss_state op=%h got=%0d exp=%0d", op, st, S_HOLD); end
        total++; if (rd_data_o !== exp) begin bad++; $display("FAIL miss_data op=%h got=%h exp=%h", op, rd_data_o, exp); end
        total++; if (rd_addr_o !== 5'd5 || rd_we_o !== 1'b1) begin bad++; $display("FAIL miss_hold_wb op=%h got rd=%0d we=%b exp rd=5 we=1", op, rd_addr_o, rd_we_o); end
        total++; if (stallreq !== 1'b0 || bus.mc_req_o !== 1'b0) begin bad++; $display("FAIL miss_hold_ctl op=%h got stall=%b req=%b exp 0 0", op, stallreq, bus.mc_req_o); end
        tick();
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL miss_release op=%h got=%0d exp=%0d", op, st, S_IDLE); end
    endtask

    task automatic test_load_hit;
        tick();
        drive_op(4'b0001, 32'h0000_2002, 32'h0, 5'd7);
        bus.dc_hit_i = 1'b1; bus.dc_rdata_i = 32'h8001_ABCD;
        #1;
        total++; if (rd_data_o !== 32'hFFFF_8001) begin bad++; $display("FAIL hit_lh_data got=%h exp=%h", rd_data_o, 32'hFFFF8001); end
        total++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd7) begin bad++; $display("FAIL hit_lh_wb got we=%b rd=%0d exp we=1 rd=7", rd_we_o, rd_addr_o); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL hit_stallreq got=%b exp=0", stallreq); end
        total++; if (bus.dc_addr_o !== 32'h0000_2002) begin bad++; $display("FAIL hit_dc_addr got=%h exp=%h", bus.dc_addr_o, 32'h2002); end
        tick();
        total++; if (bus.mc_req_o !== 1'b0 || st !== S_IDLE) begin bad++; $display("FAIL hit_no_req got req=%b st=%0d exp req=0 st=0", bus.mc_req_o, st); end
        drive_op(4'b0100, 32'h0000_2003, 32'h0, 5'd7);
        #1;
        total++; if (rd_data_o !== 32'h0000_0080) begin bad++; $display("FAIL hit_lbu_data got=%h exp=%h", rd_data_o, 32'h80); end
        drive_op(4'b0010, 32'h0000_2000, 32'h0, 5'd0);
        #1;
        total++; if (rd_data_o !== 32'h8001_ABCD || rd_we_o !== 1'b0) begin bad++; $display("FAIL hit_lw_rd0 got data=%h we=%b exp data=8001abcd we=0", rd_data_o, rd_we_o); end
        tick();
        idle_inputs();
        bus.dc_hit_i = 1'b0; bus.dc_rdata_i = 32'h0;
    endtask

    task automatic test_store;
        tick();
        drive_op(4'b1010, 32'h0000_3000, 32'hDEAD_BEEF, 5'd0);
        #1;
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL sw_stallreq got=%b exp=1", stallreq); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.mc_req_o !== 1'b1 || bus.mc_we_o !== 1'b1) begin bad++; $display("FAIL sw_req got req=%b we=%b exp 1 1", bus.mc_req_o, bus.mc_we_o); end
        total++; if (bus.mc_len_o !== 3'd4) begin bad++; $display("FAIL sw_len got=%0d exp=4", bus.mc_len_o); end
        total++; if (bus.mc_wdata_o !== 32'hDEAD_BEEF || bus.mc_addr_o !== 32'h0000_3000) begin bad++; $display("FAIL sw_bus got data=%h addr=%h exp deadbeef 3000", bus.mc_wdata_o, bus.mc_addr_o); end
        total++; if (bus.dc_wr_o !== 1'b0) begin bad++; $display("FAIL sw_dc_wr_early got=%b exp=0", bus.dc_wr_o); end
        tick();
        bus.mc_ack_i = 1'b1;
        #1;
        total++; if (bus.dc_wr_o !== 1'b1 || bus.dc_be_o !== 4'hF) begin bad++; $display("FAIL sw_dc_wr got wr=%b be=%h exp wr=1 be=f", bus.dc_wr_o, bus.dc_be_o); end
        total++; if (bus.dc_wdata_o !== 32'hDEAD_BEEF || bus.dc_addr_o !== 32'h0000_3000) begin bad++; $display("FAIL sw_dc_data got data=%h addr=%h exp deadbeef 3000", bus.dc_wdata_o, bus.dc_addr_o); end
        tick();
        bus.mc_ack_i = 1'b0;
        #1;
        total++; if (st !== S_HOLD || rd_we_o !== 1'b0 || rd_data_o !== 32'h0) begin bad++; $display("FAIL sw_hold got st=%0d we=%b data=%h exp st=2 we=0 data=0", st, rd_we_o, rd_data_o); end
        tick();
        drive_op(4'b1000, 32'h0000_3002, 32'h1234_56AB, 5'd0);
        tick();
        idle_inputs();
        #1;
        total++; if (bus.mc_len_o !== 3'd1 || bus.mc_wdata_o !== 32'h1234_56AB) begin bad++; $display("FAIL sb_bus got len=%0d data=%h exp 1 123456ab", bus.mc_len_o, bus.mc_wdata_o); end
        bus.mc_ack_i = 1'b1;
        #1;
        total++; if (bus.dc_be_o !== 4'b0100 || bus.dc_wdata_o[23:16] !== 8'hAB) begin bad++; $display("FAIL sb_dc got be=%b data=%h exp be=0100 lane2=ab", bus.dc_be_o, bus.dc_wdata_o); end
        tick();
        bus.mc_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_misalign;
        tick();
        drive_op(4'b0010, 32'h0000_4002, 32'h0, 5'd9);
        bus.dc_hit_i = 1'b1; bus.dc_rdata_i = 32'hFFFF_FFFF;
        #1;
        total++; if (misalign2 !== 1'b1 || rd_we_o2 !== 1'b0 || stallreq2 !== 1'b0) begin bad++; $display("FAIL trap_outs got mis=%b we=%b stall=%b exp 1 0 0", misalign2, rd_we_o2, stallreq2); end
        total++; if (misalign !== 1'b0 || stallreq !== 1'b1 || rd_we_o !== 1'b0) begin bad++; $display("FAIL fwd_outs got mis=%b stall=%b we=%b exp 0 1 0", misalign, stallreq, rd_we_o); end
        tick();
        idle_inputs();
        bus.dc_hit_i = 1'b0; bus.dc_rdata_i = 32'h0;
        #1;
        total++; if (bus.mc_req_o !== 1'b1 || bus.mc_addr_o !== 32'h0000_4002 || bus.mc_len_o !== 3'd4) begin bad++; $display("FAIL fwd_req got req=%b addr=%h len=%0d exp 1 4002 4", bus.mc_req_o, bus.mc_addr_o, bus.mc_len_o); end
        total++; if (bus2.mc_req_o !== 1'b0 || st2 !== S_IDLE || misalign2 !== 1'b0) begin bad++; $display("FAIL trap_after got req=%b st=%0d mis=%b exp 0 0 0", bus2.mc_req_o, st2, misalign2); end
        tick();
        bus.mc_ack_i = 1'b1; bus.mc_rdata_i = 32'h1122_3344;
        #1;
        total++; if (bus.dc_wr_o !== 1'b0) begin bad++; $display("FAIL fwd_no_fill got=%b exp=0", bus.dc_wr_o); end
        tick();
        bus.mc_ack_i = 1'b0; bus.mc_rdata_i = 32'h0;
        #1;
        total++; if (rd_data_o !== 32'h1122_3344 || rd_we_o !== 1'b1 || rd_addr_o !== 5'd9) begin bad++; $display("FAIL fwd_hold got data=%h we=%b rd=%0d exp 11223344 1 9", rd_data_o, rd_we_o, rd_addr_o); end
        tick();
    endtask

    task automatic test_hold_stall;
        tick();
        drive_op(4'b0010, 32'h0000_5000, 32'h0, 5'd3);
        tick();
        idle_inputs();
        stall = 6'b001000;
        bus.mc_ack_i = 1'b1; bus.mc_rdata_i = 32'hCAFE_F00D;
        #1;
        total++; if (bus.dc_wr_o !== 1'b1 || bus.dc_be_o !== 4'hF || bus.dc_wdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL fill got wr=%b be=%h data=%h exp 1 f cafef00d", bus.dc_wr_o, bus.dc_be_o, bus.dc_wdata_o); end
        tick();
        bus.mc_ack_i = 1'b0; bus.mc_rdata_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (st !== S_HOLD || rd_data_o !== 32'hCAFE_F00D || rd_we_o !== 1'b1) begin bad++; $display("FAIL stall_hold cyc=%0d got st=%0d data=%h we=%b exp 2 cafef00d 1", i, st, rd_data_o, rd_we_o); end
            tick();
        end
        stall = 6'b000000;
        #1;
        total++; if (st !== S_HOLD) begin bad++; $display("FAIL stall_last got=%0d exp=%0d", st, S_HOLD); end
        tick();
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL stall_release got=%0d exp=%0d", st, S_IDLE); end
    endtask

    task automatic test_rd_zero;
        tick();
        drive_op(4'b0010, 32'h0000_6000, 32'h0, 5'd0);
        tick();
        idle_inputs();
        #1;
        total++; if (bus.mc_req_o !== 1'b1) begin bad++; $display("FAIL rd0_req got=%b exp=1", bus.mc_req_o); end
        bus.mc_ack_i = 1'b1; bus.mc_rdata_i = 32'h0BAD_F00D;
        tick();
        bus.mc_ack_i = 1'b0; bus.mc_rdata_i = 32'h0;
        #1;
        total++; if (rd_we_o !== 1'b0 || rd_data_o !== 32'h0BAD_F00D) begin bad++; $display("FAIL rd0_hold got we=%b data=%h exp 0 0badf00d", rd_we_o, rd_data_o); end
        tick();
    endtask

    task automatic test_ack_outside;
        tick();
        bus.mc_ack_i = 1'b1;
        #1;
        total++; if (bus.mc_req_o !== 1'b0 || bus.dc_wr_o !== 1'b0) begin bad++; $display("FAIL stray_ack got req=%b wr=%b exp 0 0", bus.mc_req_o, bus.dc_wr_o); end
        tick();
        bus.mc_ack_i = 1'b0;
        #1;
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL stray_ack_state got=%0d exp=%0d", st, S_IDLE); end
    endtask

    task automatic test_reset_mid_req;
        tick();
        drive_op(4'b0000, 32'h0000_1001, 32'h0, 5'd5);
        tick();
        idle_inputs();
        #1;
        total++; if (bus.mc_req_o !== 1'b1) begin bad++; $display("FAIL rstreq_pre got=%b exp=1", bus.mc_req_o); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (bus.mc_req_o !== 1'b0 || bus.mc_addr_o !== 32'h0) begin bad++; $display("FAIL rstreq_drop got req=%b addr=%h exp 0 0", bus.mc_req_o, bus.mc_addr_o); end
        total++; if (st !== S_IDLE || stallreq !== 1'b0 || rd_data_o !== 32'h0) begin bad++; $display("FAIL rstreq_outs got st=%0d stall=%b data=%h exp 0 0 0", st, stallreq, rd_data_o); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (st !== S_IDLE || bus.mc_req_o !== 1'b0) begin bad++; $display("FAIL rstreq_after got st=%0d req=%b exp 0 0", st, bus.mc_req_o); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.mc_ack_i   = 1'b0;
        bus.mc_rdata_i = 32'h0;
        bus.dc_hit_i   = 1'b0;
        bus.dc_rdata_i = 32'h0;
        stall          = 6'b0;
        test_reset();
        test_passthrough();
        test_load_miss(4'b0000, 32'hFFFF_FFF0);
        test_load_miss(4'b0100, 32'h0000_00F0);
        test_load_hit();
        test_store();
        test_misalign();
        test_hold_stall();
        test_rd_zero();
        test_ack_outside();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
